// File: rtl/controls_pkg.sv
// -----------------------------------------------------------------------------
// controls_pkg
// Shared definitions for the arcade player-input block:
//   - joystick bit positions for directions and the first fire button
//   - PS/2 set-2 scan codes for the player 1 and player 2 key layouts
//   - sys_index(): position of start/coin/pause/service for a button count
//   - key_lookup(): maps a scan code onto (player, control bit)
// -----------------------------------------------------------------------------
package controls_pkg;

    // Joystick / control-word bit positions
    localparam int unsigned RIGHT = 0;
    localparam int unsigned LEFT  = 1;
    localparam int unsigned DOWN  = 2;
    localparam int unsigned UP    = 3;
    localparam int unsigned BTN0  = 4;

    // The system bits follow the fire buttons in this order
    typedef enum logic [1:0] {
        SYS_START   = 2'd0,
        SYS_COIN    = 2'd1,
        SYS_PAUSE   = 2'd2,
        SYS_SERVICE = 2'd3
    } sys_bit_e;

    // Player 1 scan codes
    localparam logic [7:0] P1_UP      = 8'h75;
    localparam logic [7:0] P1_DOWN    = 8'h72;
    localparam logic [7:0] P1_LEFT    = 8'h6B;
    localparam logic [7:0] P1_RIGHT   = 8'h74;
    localparam logic [7:0] P1_B0      = 8'h14;
    localparam logic [7:0] P1_B1      = 8'h11;
    localparam logic [7:0] P1_B2      = 8'h29;
    localparam logic [7:0] P1_START   = 8'h16;
    localparam logic [7:0] P1_COIN    = 8'h2E;
    localparam logic [7:0] P1_PAUSE   = 8'h4D;
    localparam logic [7:0] P1_SERVICE = 8'h46;

    // Player 2 scan codes (player 2 has no pause key)
    localparam logic [7:0] P2_UP      = 8'h2D;
    localparam logic [7:0] P2_DOWN    = 8'h2B;
    localparam logic [7:0] P2_LEFT    = 8'h23;
    localparam logic [7:0] P2_RIGHT   = 8'h34;
    localparam logic [7:0] P2_B0      = 8'h1C;
    localparam logic [7:0] P2_B1      = 8'h1B;
    localparam logic [7:0] P2_B2      = 8'h15;
    localparam logic [7:0] P2_START   = 8'h1E;
    localparam logic [7:0] P2_COIN    = 8'h36;
    localparam logic [7:0] P2_SERVICE = 8'h45;

    // Result of a keymap lookup: index is the bit inside the player's word
    typedef struct packed {
        logic       hit;
        logic       player;
        logic [3:0] index;
    } key_hit_t;

    function automatic int unsigned sys_index(input int unsigned num_buttons,
                                              input sys_bit_e    which);
        return BTN0 + num_buttons + {30'd0, which};
    endfunction

    // Buttons beyond num_buttons have no home in the control word, so their
    // keys are treated as unmapped rather than aliasing onto start/coin.
    function automatic key_hit_t key_lookup(input logic [7:0]  code,
                                            input int unsigned num_buttons);
        key_hit_t    k;
        int unsigned idx;
        int unsigned btn;
        logic        is_btn;
        k      = '0;
        k.hit  = 1'b1;
        idx    = 0;
        btn    = 0;
        is_btn = 1'b0;
        case (code)
            P1_RIGHT:   idx = RIGHT;
            P1_LEFT:    idx = LEFT;
            P1_DOWN:    idx = DOWN;
            P1_UP:      idx = UP;
            P1_B0:      begin is_btn = 1'b1; btn = 0; end
            P1_B1:      begin is_btn = 1'b1; btn = 1; end
            P1_B2:      begin is_btn = 1'b1; btn = 2; end
            P1_START:   idx = sys_index(num_buttons, SYS_START);
            P1_COIN:    idx = sys_index(num_buttons, SYS_COIN);
            P1_PAUSE:   idx = sys_index(num_buttons, SYS_PAUSE);
            P1_SERVICE: idx = sys_index(num_buttons, SYS_SERVICE);
            P2_RIGHT:   begin k.player = 1'b1; idx = RIGHT; end
            P2_LEFT:    begin k.player = 1'b1; idx = LEFT;  end
            P2_DOWN:    begin k.player = 1'b1; idx = DOWN;  end
            P2_UP:      begin k.player = 1'b1; idx = UP;    end
            P2_B0:      begin k.player = 1'b1; is_btn = 1'b1; btn = 0; end
            P2_B1:      begin k.player = 1'b1; is_btn = 1'b1; btn = 1; end
            P2_B2:      begin k.player = 1'b1; is_btn = 1'b1; btn = 2; end
            P2_START:   begin k.player = 1'b1; idx = sys_index(num_buttons, SYS_START);   end
            P2_COIN:    begin k.player = 1'b1; idx = sys_index(num_buttons, SYS_COIN);    end
            P2_SERVICE: begin k.player = 1'b1; idx = sys_index(num_buttons, SYS_SERVICE); end
            default:    k.hit = 1'b0;
        endcase
        if (is_btn) begin
            idx = BTN0 + btn;
            if (btn >= num_buttons) begin
                k.hit = 1'b0;
            end
        end
        k.index = 4'(idx);
        return k;
    endfunction

endpackage

// File: rtl/coin_stretch.sv
// -----------------------------------------------------------------------------
// coin_stretch
// Guarantees a minimum coin-high width. A rising edge of coin_raw loads a
// down-counter with COIN_CYCLES (also on a re-trigger while still counting);
// coin_out is the raw level ORed with "counter still running".
// Ports:
//   clk_sys   in  system clock
//   RESET     in  asynchronous active-high reset
//   coin_raw  in  merged keyboard/joystick coin level
//   coin_out  out stretched coin level (combinational, registered by the user)
// -----------------------------------------------------------------------------
module coin_stretch #(
    parameter int unsigned COIN_CYCLES = 9_600_000
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic coin_raw,
    output logic coin_out
);

    localparam int unsigned CW = $clog2(COIN_CYCLES + 1);

    logic          coin_q;
    logic [CW-1:0] count;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            coin_q <= 1'b0;
            count  <= '0;
        end else begin
            coin_q <= coin_raw;
            if (coin_raw && !coin_q) begin
                count <= CW'(COIN_CYCLES);
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign coin_out = coin_raw | (count != '0);

endmodule

// File: rtl/player_controls.sv
// -----------------------------------------------------------------------------
// player_controls
// Merges the PS/2 keyboard stream and up to four joysticks into per-player
// control words, with SOCD cleaning, global phase-aligned autofire and a
// minimum coin-pulse width. All outputs are registered.
// Ports (P = NUM_PLAYERS, B = NUM_BUTTONS, J = 8+B):
//   clk_sys   in  1      system clock
//   RESET     in  1      asynchronous active-high reset
//   ps2_key   in  11     [10] toggle, [9] pressed, [8] extended, [7:0] code
//   joystick  in  P*16   player p at [p*16 +: 16]
//   turbo_en  in  P*B    autofire enable per player/button
//   ctrl      out P*J    cleaned control word for player p at [p*J +: J]
// -----------------------------------------------------------------------------
module player_controls
    import controls_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = 2,
    parameter int unsigned NUM_BUTTONS  = 3,
    parameter int unsigned TURBO_DIV    = 3_200_000,
    parameter int unsigned COIN_CYCLES  = 9_600_000,
    parameter bit          SOCD_NEUTRAL = 1'b1
) (
    input  logic                                   clk_sys,
    input  logic                                   RESET,
    input  logic [10:0]                            ps2_key,
    input  logic [NUM_PLAYERS*16-1:0]              joystick,
    input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0]     turbo_en,
    output logic [NUM_PLAYERS*(8+NUM_BUTTONS)-1:0] ctrl
);

    localparam int unsigned J    = 8 + NUM_BUTTONS;
    localparam int unsigned COIN = sys_index(NUM_BUTTONS, SYS_COIN);
    localparam int unsigned TW   = $clog2(TURBO_DIV);

    // ------------------------------------------------------------------
    // Keyboard decoder. armed_q suppresses the first cycle after reset so
    // that a toggle level left over from before reset is not mistaken for
    // a fresh event; a key held through reset stays released until its
    // next make code.
    // ------------------------------------------------------------------
    logic              toggle_q;
    logic              armed_q;
    logic [1:0][J-1:0] keymap;
    key_hit_t          key;
    logic              key_event;
    logic              unused_ext;

    assign unused_ext = ps2_key[8];

    always_comb begin
        key       = key_lookup(ps2_key[7:0], NUM_BUTTONS);
        key_event = armed_q && (toggle_q != ps2_key[10]);
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            toggle_q <= 1'b0;
            armed_q  <= 1'b0;
            keymap   <= '0;
        end else begin
            toggle_q <= ps2_key[10];
            armed_q  <= 1'b1;
            if (key_event && key.hit && (key.player == 1'b0 || NUM_PLAYERS > 1)) begin
                keymap[key.player][key.index] <= ps2_key[9];
            end
        end
    end

    // ------------------------------------------------------------------
    // Autofire timebase: one counter shared by every button so all turbo
    // buttons fire in phase.
    // ------------------------------------------------------------------
    logic [TW-1:0] turbo_cnt;
    logic          phase;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            turbo_cnt <= '0;
            phase     <= 1'b1;
        end else if (turbo_cnt == TW'(TURBO_DIV - 1)) begin
            turbo_cnt <= '0;
            phase     <= ~phase;
        end else begin
            turbo_cnt <= turbo_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-player merge and cleaning
    // ------------------------------------------------------------------
    logic [NUM_PLAYERS*J-1:0] ctrl_next;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [J-1:0]    raw;
        logic [J-1:0]    next;
        logic            coin_out;
        logic [15-J:0]   unused_joy;

        assign unused_joy = joystick[p*16+J +: 16-J];

        // Only players 1 and 2 have keyboard layouts
        if (p < 2) begin : g_kbd
            assign raw = keymap[p] | joystick[p*16 +: J];
        end else begin : g_joy_only
            assign raw = joystick[p*16 +: J];
        end

        coin_stretch #(
            .COIN_CYCLES(COIN_CYCLES)
        ) u_coin (
            .clk_sys (clk_sys),
            .RESET   (RESET),
            .coin_raw(raw[COIN]),
            .coin_out(coin_out)
        );

        always_comb begin
            next = raw;
            if (SOCD_NEUTRAL && raw[LEFT] && raw[RIGHT]) begin
                next[LEFT]  = 1'b0;
                next[RIGHT] = 1'b0;
            end
            if (SOCD_NEUTRAL && raw[UP] && raw[DOWN]) begin
                next[UP]   = 1'b0;
                next[DOWN] = 1'b0;
            end
            for (int unsigned b = 0; b < NUM_BUTTONS; b++) begin
                if (turbo_en[p*NUM_BUTTONS + b] && !phase) begin
                    next[BTN0 + b] = 1'b0;
                end
            end
            next[COIN] = coin_out;
        end

        assign ctrl_next[p*J +: J] = next;
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            ctrl <= '0;
        end else begin
            ctrl <= ctrl_next;
        end
    end

endmodule

// File: doc/player_controls.md
# player_controls

Parametrised player-input block for the arcade cores. It merges the PS/2 keyboard stream and up to four MiSTer joysticks into per-player control vectors, and adds per-button autofire, a minimum coin-pulse width and SOCD (opposing-direction) cleaning. It sits between `hps_io` and the game core in `clk_sys`. It replaces the hand-written key decoder and OR-merge in each core's `emu` top.

## Interface
Parameters:
- NUM_PLAYERS, 2, players supported (1..4); the keyboard drives players 1–2 only.
- NUM_BUTTONS, 3, fire buttons per player (1..6).
- TURBO_DIV, 3_200_000, `clk_sys` cycles per autofire half-period (≥2).
- COIN_CYCLES, 9_600_000, minimum coin-high width in cycles (≥1).
- SOCD_NEUTRAL, 1, 1 = left+right → neither and up+down → neither; 0 = pass through.

Ports (P = NUM_PLAYERS, B = NUM_BUTTONS, J = 8+B):
- clk_sys  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-high.
- ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [8] extended (ignored), [7:0] scan code.
- joystick  in  P*16  player p at [p*16 +: 16]. Bits: [0] right, [1] left, [2] down, [3] up, [4+b] button b, [4+B] start, [5+B] coin, [6+B] pause, [7+B] service.
- turbo_en  in  P*B  autofire enable per player/button; sampled live.
- ctrl  out  P*J  cleaned control word for player p at [p*J +: J], in the same bit order as the joystick bits above.

## Operation
- Keyboard decoder: registers `ps2_key[10]`. When the registered value differs from the current input, the entry in the keymap whose code equals `ps2_key[7:0]` is set to `ps2_key[9]`. Unmapped codes are ignored.
- Keymap, player 1: up 75, down 72, left 6B, right 74, b0 14, b1 11, b2 29, start 16, coin 2E, pause 4D, service 46.
- Keymap, player 2: up 2D, down 2B, left 23, right 34, b0 1C, b1 1B, b2 15, start 1E, coin 36, service 45; pause has no key.
- Buttons b≥3 and players 3–4 have no keys.
- raw[p] = keymap[p] | joystick bits of player p.
- SOCD: with SOCD_NEUTRAL=1, if raw left & raw right, both outputs are 0; the same rule applies to up/down.
- Autofire: a free-running counter counts 0..TURBO_DIV-1 and toggles `phase` on wrap; `phase` resets to 1.
  - Button output = raw & (turbo_en ? phase : 1).
  - Enabling turbo mid-hold takes effect on the next cycle.
- Coin stretch, one counter per player:
  - Rising edge of raw coin loads COIN_CYCLES.
  - Counter decrements to 0.
  - Coin output = raw coin | (counter ≠ 0).
  - A new rising edge while the counter is nonzero reloads it.
- Start, pause, service and directions (after SOCD) pass through with no filtering.
- Reset: all keymap bits, counters and `ctrl` = 0; `phase` = 1. Reset mid-press clears the output immediately; a key held through reset stays 0 until its next make event.

## Timing
- All outputs are registered.
- Joystick → ctrl latency: 1 cycle.
- ps2_key toggle → ctrl latency: 2 cycles (keymap register, then output register).
- Autofire period is 2*TURBO_DIV cycles at 50 % duty, global and phase-aligned across all buttons.
- Coin width is COIN_CYCLES+1 cycles for a 1-cycle raw pulse, from the first output-high cycle.
- A simultaneous keyboard and joystick press on the same bit ORs with no glitch.
- Two toggles on consecutive cycles are both processed.

## Structure
- `controls_pkg` holds:
  - joystick bit-index constants (RIGHT, LEFT, DOWN, UP, BTN0);
  - the P1/P2 scan-code constants;
  - a function returning the start/coin/pause/service index for a given B.
- Sub-module `coin_stretch` (one instance per player): the edge detector plus load/decrement counter, parameter COIN_CYCLES.

## Test plan
Parameters for all scenarios: P=2, B=3, TURBO_DIV=4, COIN_CYCLES=5.
- Reset: hold RESET, drive joystick all ones → ctrl = 0. Release → ctrl[10:0] = 7FF after 1 cycle, except SOCD makes [3:0] = 0.
- Keyboard:
  - Toggle ps2_key with pressed=1, code 6B → P1 left high 2 cycles later.
  - Same code with pressed=0 → low 2 cycles later.
  - Code 99 → no change.
- SOCD: joystick P1 = 0x003 → right = left = 0. Set SOCD_NEUTRAL=0 → both 1.
- Autofire: turbo_en[0]=1, hold P1 b0 → output toggles every 4 cycles (period 8). turbo_en=0 → steady 1.
- Coin:
  - 1-cycle coin pulse → coin output high for exactly 6 cycles.
  - Second pulse at cycle 3 → high until cycle 3+6.
- Reset mid-hold: assert RESET while key 14 is held → ctrl = 0. No output until a new make code arrives.
